// File: rtl/pixel_stream_sequencer.sv
// -----------------------------------------------------------------------------
// pixel_stream_sequencer
//
// Frame-level master for the chromatic-adaptation pixel path. On start it walks
// the source frame memory, buffers the returned RGB888 words in a small FIFO,
// offers them to the image processor over a valid/ready handshake, and writes
// every compensated pixel that comes back (valid-only, no backpressure) to the
// destination frame memory at consecutive addresses.
//
// Optional feature (compile-time macro):
//   PSS_CHECKSUM_EN  - when defined, checksum is a 16-bit wrapping sum of
//                      R+G+B of every written pixel, cleared when a start is
//                      accepted. When undefined checksum is tied to zero.
//
// Parameters
//   ADDR_W        word address width of both memory ports and of pixel_count
//   FIFO_DEPTH    read-data buffer entries (power of 2, >= 2)
//   MAX_INFLIGHT  max pixels accepted by the processor but not yet returned
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  one-cycle start request, honoured only when idle
//   src_base, dst_base     first source / destination address (latched on start)
//   pixel_count            pixels in the frame (latched on start)
//   rd_en, rd_addr         source read strobe / address
//   rd_data                source data, valid one cycle after rd_en
//   pix_rgb, pix_valid     pixel offered to the processor
//   pix_ready              processor accepts the offered pixel
//   proc_rgb, proc_valid   compensated pixel returned by the processor
//   wr_en, wr_addr, wr_data destination write port
//   busy                   frame in progress (RUN and FINISH)
//   done                   one-cycle end-of-frame pulse
//   error                  sticky: proc_valid with nothing in flight
//   checksum               frame checksum (see PSS_CHECKSUM_EN)
// -----------------------------------------------------------------------------
module pixel_stream_sequencer #(
    parameter int ADDR_W       = 18,
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] pixel_count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [23:0]       rd_data,
    output logic [23:0]       pix_rgb,
    output logic              pix_valid,
    input  logic              pix_ready,
    input  logic [23:0]       proc_rgb,
    input  logic              proc_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       checksum
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t            state_q,       state_d;
    logic [ADDR_W-1:0] src_base_q,    src_base_d;
    logic [ADDR_W-1:0] dst_base_q,    dst_base_d;
    logic [ADDR_W-1:0] count_q,       count_d;
    logic [ADDR_W-1:0] rd_issued_q,   rd_issued_d;
    logic [ADDR_W-1:0] wr_count_q,    wr_count_d;
    logic              rd_pend_q,     rd_pend_d;
    logic [PTR_W-1:0]  fifo_wr_ptr_q, fifo_wr_ptr_d;
    logic [PTR_W-1:0]  fifo_rd_ptr_q, fifo_rd_ptr_d;
    logic [OCC_W-1:0]  fifo_occ_q,    fifo_occ_d;
    logic [INF_W-1:0]  inflight_q,    inflight_d;
    logic              wr_en_q,       wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,     wr_addr_d;
    logic [23:0]       wr_data_q,     wr_data_d;
    logic              error_q,       error_d;

    // Read-data buffer storage; no reset needed because occupancy gates use.
    logic [23:0]       fifo_mem [FIFO_DEPTH];

    logic              is_run;
    logic              start_accept;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [OCC_W:0]    fill_level;
    logic              rd_en_int;
    logic              pix_valid_int;
    logic              issue;
    logic              ret_ok;
    logic              spurious;

    // ------------------------------------------------------------------
    // Datapath qualifiers
    // ------------------------------------------------------------------
    always_comb begin
        is_run        = (state_q == S_RUN);
        start_accept  = (state_q == S_IDLE) && start;
        fifo_empty    = (fifo_occ_q == '0);
        // Reads already issued but not yet landed must be counted as
        // occupied, otherwise the returning word could overflow the FIFO.
        fill_level    = {1'b0, fifo_occ_q} + {{OCC_W{1'b0}}, rd_pend_q};
        rd_en_int     = is_run && (rd_issued_q < count_q) &&
                        (fill_level < (OCC_W+1)'(FIFO_DEPTH));
        pix_valid_int = !fifo_empty && (inflight_q < INF_W'(MAX_INFLIGHT));
        issue         = pix_valid_int && pix_ready;
        // A returned pixel is only legitimate if something is outstanding.
        ret_ok        = proc_valid && is_run && (inflight_q != '0);
        spurious      = proc_valid && !ret_ok;
        fifo_push     = rd_pend_q;
        fifo_pop      = issue;
    end

    // ------------------------------------------------------------------
    // Next-state and register-input logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        src_base_d    = src_base_q;
        dst_base_d    = dst_base_q;
        count_d       = count_q;
        rd_issued_d   = rd_issued_q;
        wr_count_d    = wr_count_q;
        rd_pend_d     = rd_en_int;
        fifo_wr_ptr_d = fifo_wr_ptr_q;
        fifo_rd_ptr_d = fifo_rd_ptr_q;
        fifo_occ_d    = fifo_occ_q;
        inflight_d    = inflight_q;
        wr_en_d       = ret_ok;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        error_d       = error_q;

        if (rd_en_int) begin
            rd_issued_d = rd_issued_q + ADDR_W'(1);
        end

        if (fifo_push) begin
            fifo_wr_ptr_d = fifo_wr_ptr_q + PTR_W'(1);
        end
        if (fifo_pop) begin
            fifo_rd_ptr_d = fifo_rd_ptr_q + PTR_W'(1);
        end
        case ({fifo_push, fifo_pop})
            2'b10:   fifo_occ_d = fifo_occ_q + OCC_W'(1);
            2'b01:   fifo_occ_d = fifo_occ_q - OCC_W'(1);
            default: fifo_occ_d = fifo_occ_q;
        endcase

        case ({issue, ret_ok})
            2'b10:   inflight_d = inflight_q + INF_W'(1);
            2'b01:   inflight_d = inflight_q - INF_W'(1);
            default: inflight_d = inflight_q;
        endcase

        // Writeback address is taken from the pre-increment write count so
        // the n-th returned pixel lands at dst_base + n.
        if (ret_ok) begin
            wr_addr_d  = dst_base_q + wr_count_q;
            wr_data_d  = proc_rgb;
            wr_count_d = wr_count_q + ADDR_W'(1);
        end

        if (spurious) begin
            error_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_base_d    = src_base;
                    dst_base_d    = dst_base;
                    count_d       = pixel_count;
                    rd_issued_d   = '0;
                    wr_count_d    = '0;
                    rd_pend_d     = 1'b0;
                    fifo_wr_ptr_d = '0;
                    fifo_rd_ptr_d = '0;
                    fifo_occ_d    = '0;
                    inflight_d    = '0;
                    state_d       = (pixel_count == '0) ? S_FINISH : S_RUN;
                end
            end
            S_RUN: begin
                // wr_count_q already includes the write being driven now.
                if (wr_en_q && (wr_count_q == count_q)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            src_base_q    <= '0;
            dst_base_q    <= '0;
            count_q       <= '0;
            rd_issued_q   <= '0;
            wr_count_q    <= '0;
            rd_pend_q     <= 1'b0;
            fifo_wr_ptr_q <= '0;
            fifo_rd_ptr_q <= '0;
            fifo_occ_q    <= '0;
            inflight_q    <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            src_base_q    <= src_base_d;
            dst_base_q    <= dst_base_d;
            count_q       <= count_d;
            rd_issued_q   <= rd_issued_d;
            wr_count_q    <= wr_count_d;
            rd_pend_q     <= rd_pend_d;
            fifo_wr_ptr_q <= fifo_wr_ptr_d;
            fifo_rd_ptr_q <= fifo_rd_ptr_d;
            fifo_occ_q    <= fifo_occ_d;
            inflight_q    <= inflight_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            error_q       <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[fifo_wr_ptr_q] <= rd_data;
        end
    end

`ifdef PSS_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (start_accept) begin
            csum_d = '0;
        end else if (wr_en_q) begin
            csum_d = csum_q + 16'(wr_data_q[23:16]) + 16'(wr_data_q[15:8])
                            + 16'(wr_data_q[7:0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = 16'h0000;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_en     = rd_en_int;
    assign rd_addr   = src_base_q + rd_issued_q;
    assign pix_valid = pix_valid_int;
    // Masked when not valid so the bus reads zero after reset.
    assign pix_rgb   = pix_valid_int ? fifo_mem[fifo_rd_ptr_q] : 24'h0;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FINISH);
    assign error     = error_q;

endmodule

// File: tb/tb_pixel_stream_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for pixel_stream_sequencer. A frame table drives whole frames
// through a source-memory model and a fixed-latency echo processor model;
// hand-written sequences cover zero-length frames, spurious returns and
// reset in the middle of a frame.
// -----------------------------------------------------------------------------
module tb_pixel_stream_sequencer;

    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] src_base, dst_base, pixel_count;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [23:0]   rd_data;
    logic [23:0]   pix_rgb;
    logic          pix_valid;
    logic          pix_ready;
    logic [23:0]   proc_rgb;
    logic          proc_valid;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic          busy, done, error;
    logic [15:0]   checksum;

    always #5 clk = ~clk;

    pixel_stream_sequencer #(.ADDR_W(AW), .FIFO_DEPTH(4), .MAX_INFLIGHT(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_base(src_base), .dst_base(dst_base), .pixel_count(pixel_count),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .pix_rgb(pix_rgb), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .proc_rgb(proc_rgb), .proc_valid(proc_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .error(error), .checksum(checksum)
    );

    typedef struct {
        int            count;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        int            lat;
        int            stall_at;
        int            stall_len;
        int            exp_max_infl;
        int            exp_fifo_full;
        logic          exp_error;
        int            exp_csum;     // -1: use running model sum
    } frame_t;

    typedef struct {
        logic [23:0] rgb;
        int          due;
    } pend_t;

    frame_t        frames [6];
    pend_t         pq [$];

    int            checks = 0;
    int            errors = 0;
    int            cyc, lat;
    int            rd_cnt, pop_cnt, wr_cnt, done_cnt;
    int            max_infl, max_fifo;
    logic          rd_pend;
    logic [AW-1:0] rd_pend_addr;
    logic          spur;
    logic          prev_v, prev_r;
    logic [23:0]   prev_rgb;
    logic [AW-1:0] exp_src, exp_dst;
    logic [15:0]   csum_m;

    function automatic logic [23:0] src_fn(input logic [AW-1:0] a);
        if (a >= 18'h20000 && a < 18'h20100) return 24'hFFFFFF;
        return {a[7:0], ~a[7:0], a[15:8] ^ a[7:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        cyc = 0; rd_cnt = 0; pop_cnt = 0; wr_cnt = 0; done_cnt = 0;
        max_infl = 0; max_fifo = 0; rd_pend = 1'b0; rd_pend_addr = '0;
        prev_v = 1'b0; prev_r = 1'b0; prev_rgb = '0; csum_m = '0;
        proc_valid = 1'b0; proc_rgb = '0; rd_data = '0;
        pq.delete();
    endtask

    // Runs at the falling edge: models memory and processor, checks outputs.
    task automatic monitor();
        logic [AW-1:0] ea;
        logic [23:0]   px;
        pend_t         p;
        cyc++;
        rd_data = rd_pend ? src_fn(rd_pend_addr) : 24'h0;
        rd_pend = rd_en;
        rd_pend_addr = rd_addr;
        if (rd_en) begin
            ea = exp_src + AW'(rd_cnt);
            chk("rd_addr", 32'(rd_addr), 32'(ea));
            rd_cnt++;
        end
        if (pq.size() != 0 && pq[0].due == cyc) begin
            proc_valid = 1'b1;
            proc_rgb   = pq[0].rgb;
            void'(pq.pop_front());
        end else begin
            proc_valid = spur;
            proc_rgb   = spur ? 24'hABCDEF : 24'h0;
        end
        if (prev_v && !prev_r) begin
            chk("hold_valid", 32'(pix_valid), 32'd1);
            chk("hold_rgb", 32'(pix_rgb), 32'(prev_rgb));
        end
        if (pix_valid && pix_ready) begin
            ea = exp_src + AW'(pop_cnt);
            chk("pix_rgb", 32'(pix_rgb), 32'(src_fn(ea)));
            pop_cnt++;
            p.rgb = pix_rgb;
            p.due = cyc + lat;
            pq.push_back(p);
            if (pq.size() > max_infl) max_infl = pq.size();
        end
        prev_v = pix_valid; prev_r = pix_ready; prev_rgb = pix_rgb;
        if (rd_cnt - pop_cnt > max_fifo) max_fifo = rd_cnt - pop_cnt;
        if (wr_en) begin
            ea = exp_dst + AW'(wr_cnt);
            chk("wr_addr", 32'(wr_addr), 32'(ea));
            ea = exp_src + AW'(wr_cnt);
            px = src_fn(ea);
            chk("wr_data", 32'(wr_data), 32'(px));
            csum_m = csum_m + 16'(px[23:16]) + 16'(px[15:8]) + 16'(px[7:0]);
            wr_cnt++;
        end
        if (done) done_cnt++;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_en"},     32'(rd_en),     32'd0);
        chk({tag, "_rd_addr"},   32'(rd_addr),   32'd0);
        chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
        chk({tag, "_pix_rgb"},   32'(pix_rgb),   32'd0);
        chk({tag, "_wr_en"},     32'(wr_en),     32'd0);
        chk({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
        chk({tag, "_wr_data"},   32'(wr_data),   32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
        chk({tag, "_error"},     32'(error),     32'd0);
        chk({tag, "_checksum"},  32'(checksum),  32'd0);
    endtask

    task automatic run_frame(input int i);
        int    k;
        logic [15:0] exp_cs;
        clear_model();
        exp_src     = frames[i].src;
        exp_dst     = frames[i].dst;
        lat         = frames[i].lat;
        src_base    = frames[i].src;
        dst_base    = frames[i].dst;
        pixel_count = AW'(frames[i].count);
        pix_ready   = 1'b1;
        start       = 1'b1;
        tick();
        start = 1'b0;
        chk("frame_busy_after_start", 32'(busy), 32'd1);
        k = 0;
        while (k < 3000 && done_cnt == 0) begin
            pix_ready = !(frames[i].stall_at >= 0 && k >= frames[i].stall_at &&
                          k < frames[i].stall_at + frames[i].stall_len);
            tick();
            k++;
        end
        chk("frame_done_seen", 32'(done_cnt != 0), 32'd1);
        pix_ready = 1'b1;
        repeat (3) tick();
`ifdef PSS_CHECKSUM_EN
        exp_cs = (frames[i].exp_csum >= 0) ? 16'(frames[i].exp_csum) : csum_m;
`else
        exp_cs = 16'h0000;
`endif
        chk("frame_writes",   32'(wr_cnt),   32'(frames[i].count));
        chk("frame_reads",    32'(rd_cnt),   32'(frames[i].count));
        chk("frame_pops",     32'(pop_cnt),  32'(frames[i].count));
        chk("frame_done_cnt", 32'(done_cnt), 32'd1);
        chk("frame_busy_end", 32'(busy),     32'd0);
        chk("frame_error",    32'(error),    32'(frames[i].exp_error));
        chk("frame_max_inflight", 32'(max_infl), 32'(frames[i].exp_max_infl));
        if (frames[i].exp_fifo_full != 0)
            chk("frame_fifo_full", 32'(max_fifo), 32'd4);
        else
            chk("frame_fifo_bound", 32'(max_fifo <= 4), 32'd1);
        chk("frame_checksum", 32'(checksum), 32'(exp_cs));
        $display("frame %0d: count=%0d writes=%0d max_inflight=%0d max_fifo=%0d checksum=0x%04h",
                 i, frames[i].count, wr_cnt, max_infl, max_fifo, checksum);
    endtask

    initial begin
        //           count src        dst        lat stall len infl full err csum
        frames[0] = '{4,  18'h00100, 18'h00200, 1,  -1,   0,  1,   0,   1'b0, -1};
        frames[1] = '{16, 18'h00040, 18'h03000, 1,  6,    20, 1,   1,   1'b0, -1};
        frames[2] = '{20, 18'h00010, 18'h00500, 12, -1,   0,  8,   1,   1'b0, -1};
        frames[3] = '{5,  18'h3FFFE, 18'h3FFFD, 1,  -1,   0,  1,   0,   1'b0, -1};
        frames[4] = '{2,  18'h20000, 18'h01000, 1,  -1,   0,  1,   0,   1'b1, 'h05FA};
        frames[5] = '{1,  18'h00077, 18'h00000, 3,  -1,   0,  1,   0,   1'b1, -1};

        rst_n = 1'b0; start = 1'b0; pix_ready = 1'b0; spur = 1'b0;
        src_base = '0; dst_base = '0; pixel_count = '0;
        exp_src = '0; exp_dst = '0; lat = 1;
        clear_model();
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) run_frame(i);

        // Zero-length frame: FINISH straight from IDLE, no memory traffic.
        clear_model();
        pixel_count = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_busy", 32'(busy), 32'd1);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_rd_en", 32'(rd_en), 32'd0);
        tick();
        chk("zero_busy_off", 32'(busy), 32'd0);
        chk("zero_done_off", 32'(done), 32'd0);
        tick();
        chk("zero_reads", 32'(rd_cnt), 32'd0);
        chk("zero_writes", 32'(wr_cnt), 32'd0);
        chk("zero_done_cnt", 32'(done_cnt), 32'd1);
        chk("zero_checksum", 32'(checksum), 32'd0);
        $display("zero-length frame: done_cnt=%0d reads=%0d writes=%0d", done_cnt, rd_cnt, wr_cnt);

        // Spurious return while idle.
        clear_model();
        chk("spur_error_before", 32'(error), 32'd0);
        spur = 1'b1;
        tick();
        spur = 1'b0;
        chk("spur_error", 32'(error), 32'd1);
        chk("spur_wr_en", 32'(wr_en), 32'd0);
        tick();
        chk("spur_wr_en_next", 32'(wr_en), 32'd0);
        chk("spur_writes", 32'(wr_cnt), 32'd0);
        chk("spur_error_sticky", 32'(error), 32'd1);
        $display("spurious proc_valid: error=%0d writes=%0d", error, wr_cnt);

        for (int i = 4; i < 6; i++) run_frame(i);

        // Reset in the middle of a frame.
        clear_model();
        exp_src = 18'h00080; exp_dst = 18'h00900; lat = 4;
        src_base = exp_src; dst_base = exp_dst; pixel_count = AW'(16);
        pix_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("midrst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        clear_model();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("midrst_done_cnt", 32'(done_cnt), 32'd0);
        chk("midrst_reads", 32'(rd_cnt), 32'd0);
        chk("midrst_writes", 32'(wr_cnt), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        $display("mid-frame reset: done_cnt=%0d reads=%0d writes=%0d", done_cnt, rd_cnt, wr_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
